// File: rtl/wav_pkg.sv
// Shared definitions for the 8-sample WAV block interface.
// The packer and the consumer core both use this package.
package wav_pkg;

  localparam int SAMPLE_W = 16;
  localparam int BLOCK_N  = 8;
  localparam int CNT_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } packer_state_t;

endpackage

// File: rtl/wav_block_slots.sv
// Block register file: BLOCK_N sample slots with indexed write and synchronous clear.
// Slot 0 is the oldest sample of the block and drives o_sample1.
module wav_block_slots
  import wav_pkg::*;
#(
  parameter int SAMPLE_W = wav_pkg::SAMPLE_W,
  parameter int BLOCK_N  = wav_pkg::BLOCK_N
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_we,
  input  logic [3:0]          i_idx,
  input  logic [SAMPLE_W-1:0] i_data,
  output logic [SAMPLE_W-1:0] o_sample1,
  output logic [SAMPLE_W-1:0] o_sample2,
  output logic [SAMPLE_W-1:0] o_sample3,
  output logic [SAMPLE_W-1:0] o_sample4,
  output logic [SAMPLE_W-1:0] o_sample5,
  output logic [SAMPLE_W-1:0] o_sample6,
  output logic [SAMPLE_W-1:0] o_sample7,
  output logic [SAMPLE_W-1:0] o_sample8
);

  logic [SAMPLE_W-1:0] r_slot [BLOCK_N];

  // Slot storage: reset and clear take priority over a write.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < BLOCK_N; i++) begin
      if (i_rst || i_clr) begin
        r_slot[i] <= {SAMPLE_W{1'b0}};
      end else if (i_we && (i_idx == 4'(i))) begin
        r_slot[i] <= i_data;
      end else begin
        r_slot[i] <= r_slot[i];
      end
    end
  end

  assign o_sample1 = r_slot[0];
  assign o_sample2 = r_slot[1];
  assign o_sample3 = r_slot[2];
  assign o_sample4 = r_slot[3];
  assign o_sample5 = r_slot[4];
  assign o_sample6 = r_slot[5];
  assign o_sample7 = r_slot[6];
  assign o_sample8 = r_slot[7];

endmodule

// File: rtl/wav_block_packer.sv
// Packs a valid/ready stream of PCM samples into BLOCK_N-sample blocks, zero-padding
// the final partial block and flagging end of file once load_size samples are delivered.
module wav_block_packer
  import wav_pkg::*;
#(
  parameter int SAMPLE_W = wav_pkg::SAMPLE_W,
  parameter int BLOCK_N  = wav_pkg::BLOCK_N
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_load_size,
  input  logic                i_in_valid,
  input  logic [SAMPLE_W-1:0] i_in_sample,
  output logic                o_in_ready,
  output logic                o_buffer_load,
  input  logic                i_block_ready,
  output logic [SAMPLE_W-1:0] o_sample1,
  output logic [SAMPLE_W-1:0] o_sample2,
  output logic [SAMPLE_W-1:0] o_sample3,
  output logic [SAMPLE_W-1:0] o_sample4,
  output logic [SAMPLE_W-1:0] o_sample5,
  output logic [SAMPLE_W-1:0] o_sample6,
  output logic [SAMPLE_W-1:0] o_sample7,
  output logic [SAMPLE_W-1:0] o_sample8,
  output logic [3:0]          o_valid_count,
  output logic                o_last_block,
  output logic                o_wav_done
);

  localparam logic [3:0] LP_BLOCK_N = 4'(BLOCK_N);

  packer_state_t    r_state;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_fill;
  logic             r_in_ready;
  logic             r_buffer_load;
  logic             r_last_block;
  logic             r_wav_done;

  logic             w_accept;
  logic             w_handshake;
  logic             w_start_ok;
  logic             w_slot_clr;
  logic [3:0]       w_fill_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // Handshake decode and slot-clear request; buffer_load is only high in PRESENT.
  always_comb begin
    w_accept    = i_in_valid & r_in_ready;
    w_handshake = r_buffer_load & i_block_ready;
    w_start_ok  = i_start & ((r_state == IDLE) | (r_state == DONE));
    w_fill_nxt  = r_fill + 4'd1;
    w_count_nxt = r_count + CNT_W'(1);
    if (w_start_ok && (i_load_size != {CNT_W{1'b0}})) begin
      w_slot_clr = 1'b1;
    end else if (w_handshake && !r_last_block) begin
      w_slot_clr = 1'b1;
    end else begin
      w_slot_clr = 1'b0;
    end
  end

  // Packer FSM with counters; all flag outputs are registered next to the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_total       <= {CNT_W{1'b0}};
      r_count       <= {CNT_W{1'b0}};
      r_fill        <= 4'd0;
      r_in_ready    <= 1'b0;
      r_buffer_load <= 1'b0;
      r_last_block  <= 1'b0;
      r_wav_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_total      <= i_load_size;
            r_count      <= {CNT_W{1'b0}};
            r_fill       <= 4'd0;
            r_last_block <= 1'b0;
            if (i_load_size == {CNT_W{1'b0}}) begin
              r_state    <= DONE;
              r_in_ready <= 1'b0;
              r_wav_done <= 1'b1;
            end else begin
              r_state    <= FILL;
              r_in_ready <= 1'b1;
              r_wav_done <= 1'b0;
            end
          end
        end
        FILL: begin
          if (w_accept) begin
            r_fill  <= w_fill_nxt;
            r_count <= w_count_nxt;
            if ((w_fill_nxt == LP_BLOCK_N) || (w_count_nxt == r_total)) begin
              r_state       <= PRESENT;
              r_in_ready    <= 1'b0;
              r_buffer_load <= 1'b1;
              r_last_block  <= (w_count_nxt == r_total);
            end
          end
        end
        PRESENT: begin
          if (w_handshake) begin
            r_buffer_load <= 1'b0;
            if (r_last_block) begin
              r_state    <= DONE;
              r_wav_done <= 1'b1;
            end else begin
              r_state    <= FILL;
              r_fill     <= 4'd0;
              r_in_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_in_ready    <= 1'b0;
          r_buffer_load <= 1'b0;
          r_last_block  <= 1'b0;
          r_wav_done    <= 1'b0;
        end
      endcase
    end
  end

  wav_block_slots #(
    .SAMPLE_W (SAMPLE_W),
    .BLOCK_N  (BLOCK_N)
  ) u_slots (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_slot_clr),
    .i_we      (w_accept),
    .i_idx     (r_fill),
    .i_data    (i_in_sample),
    .o_sample1 (o_sample1),
    .o_sample2 (o_sample2),
    .o_sample3 (o_sample3),
    .o_sample4 (o_sample4),
    .o_sample5 (o_sample5),
    .o_sample6 (o_sample6),
    .o_sample7 (o_sample7),
    .o_sample8 (o_sample8)
  );

  assign o_in_ready    = r_in_ready;
  assign o_buffer_load = r_buffer_load;
  assign o_valid_count = r_fill;
  assign o_last_block  = r_last_block;
  assign o_wav_done    = r_wav_done;

endmodule

// File: tb/tb_wav_block_packer.sv
// Scoreboard bench for wav_block_packer: each file's expected blocks are computed from
// its sample list up front; a monitor pops and compares on every block handshake.
module tb_wav_block_packer;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   vc;
    logic         last;
  } blk_t;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_load_size;
  logic        i_in_valid;
  logic [15:0] i_in_sample;
  logic        o_in_ready;
  logic        o_buffer_load;
  logic        i_block_ready;
  logic [15:0] o_sample1, o_sample2, o_sample3, o_sample4;
  logic [15:0] o_sample5, o_sample6, o_sample7, o_sample8;
  logic [3:0]  o_valid_count;
  logic        o_last_block;
  logic        o_wav_done;

  int   errors = 0;
  int   checks = 0;
  blk_t sbq[$];

  wav_block_packer dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_load_size   (i_load_size),
    .i_in_valid    (i_in_valid),
    .i_in_sample   (i_in_sample),
    .o_in_ready    (o_in_ready),
    .o_buffer_load (o_buffer_load),
    .i_block_ready (i_block_ready),
    .o_sample1     (o_sample1),
    .o_sample2     (o_sample2),
    .o_sample3     (o_sample3),
    .o_sample4     (o_sample4),
    .o_sample5     (o_sample5),
    .o_sample6     (o_sample6),
    .o_sample7     (o_sample7),
    .o_sample8     (o_sample8),
    .o_valid_count (o_valid_count),
    .o_last_block  (o_last_block),
    .o_wav_done    (o_wav_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the falling edge; outputs are read there too.
  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  function automatic logic [127:0] cur_block();
    return {o_sample8, o_sample7, o_sample6, o_sample5,
            o_sample4, o_sample3, o_sample2, o_sample1};
  endfunction

  task automatic check_reset_outputs();
    chk("rst_in_ready", 128'(o_in_ready), 128'd0);
    chk("rst_buffer_load", 128'(o_buffer_load), 128'd0);
    chk("rst_samples", cur_block(), 128'd0);
    chk("rst_valid_count", 128'(o_valid_count), 128'd0);
    chk("rst_last_block", 128'(o_last_block), 128'd0);
    chk("rst_wav_done", 128'(o_wav_done), 128'd0);
  endtask

  // Monitor: after inputs settle, a block handshake pops and compares one expected block.
  logic [127:0] prev_data;
  logic [4:0]   prev_meta;
  bit           pend = 1'b0;
  always @(negedge i_clk) begin
    blk_t e;
    #2;
    if (i_rst) begin
      pend = 1'b0;
    end else if (o_buffer_load) begin
      if (pend) begin
        chk("hold_samples", cur_block(), prev_data);
        chk("hold_meta", 128'({o_valid_count, o_last_block}), 128'(prev_meta));
      end
      chk("ready_low_in_present", 128'(o_in_ready), 128'd0);
      if (i_block_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block: got %h expected none", cur_block());
        end else begin
          e = sbq.pop_front();
          chk("blk_samples", cur_block(), e.data);
          chk("blk_valid_count", 128'(o_valid_count), 128'(e.vc));
          chk("blk_last", 128'(o_last_block), 128'(e.last));
        end
        pend = 1'b0;
      end else begin
        pend = 1'b1;
      end
      prev_data = cur_block();
      prev_meta = {o_valid_count, o_last_block};
    end else begin
      pend = 1'b0;
    end
  end

  // vmode: 0 always valid, 1 toggle, 2 random. rmode: 0 always ready, 2 random, 3 hold 5.
  task automatic run_file(input int load, input int vmode, input int rmode,
                          input bit seq, input bit mid_start);
    logic [15:0] smp[$];
    blk_t e;
    int   nblk, idx, cyc, bp_hold, budget, rem;
    bit   done, v;
    smp = {};
    for (int i = 0; i < load; i++) smp.push_back(seq ? 16'(i + 1) : 16'($urandom));
    nblk = (load + 7) / 8;
    for (int b = 0; b < nblk; b++) begin
      e.data = 128'd0;
      for (int j = 0; j < 8; j++)
        if (b * 8 + j < load) e.data[j*16 +: 16] = smp[b * 8 + j];
      rem    = load - b * 8;
      e.vc   = 4'((rem > 8) ? 8 : rem);
      e.last = (b == nblk - 1);
      sbq.push_back(e);
    end
    budget = 20 * load + 100;
    i_load_size = 32'(load);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_load_size = $urandom;
    cyc = 1;
    idx = 0;
    bp_hold = 0;
    done = 1'b0;
    chk("start_in_ready", 128'(o_in_ready), 128'(load > 0));
    chk("start_wav_done", 128'(o_wav_done), 128'(load == 0));
    while (cyc < budget) begin
      if (o_wav_done) begin
        done = 1'b1;
        break;
      end
      if (mid_start && cyc == 4) begin
        i_start = 1'b1;
        i_load_size = 32'd5;
      end else begin
        i_start = 1'b0;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (idx >= load) v = 1'b0;
      i_in_valid  = v;
      i_in_sample = (idx < load) ? smp[idx] : 16'($urandom);
      if (rmode == 3) begin
        if (o_buffer_load) begin
          if (bp_hold < 5) begin
            i_block_ready = 1'b0;
            bp_hold++;
          end else begin
            i_block_ready = 1'b1;
          end
        end else begin
          i_block_ready = 1'b0;
          bp_hold = 0;
        end
      end else if (rmode == 2) begin
        i_block_ready = 1'($urandom_range(0, 1));
      end else begin
        i_block_ready = 1'b1;
      end
      if (v && o_in_ready) idx++;
      tick();
      cyc++;
    end
    i_start = 1'b0;
    i_in_valid = 1'b0;
    i_block_ready = 1'b1;
    chk("done_reached", 128'(done), 128'd1);
    if (vmode == 0 && rmode == 0) chk("done_cycle", 128'(cyc), 128'(1 + load + nblk));
    if (vmode == 0 && rmode == 3) chk("done_cycle_bp", 128'(cyc), 128'(1 + load + 6 * nblk));
    chk("blocks_all_seen", 128'(sbq.size()), 128'd0);
    tick();
    chk("done_hold", 128'(o_wav_done), 128'(done));
    chk("done_no_ready", 128'(o_in_ready), 128'd0);
  endtask

  initial begin
    int acc, guard;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_load_size = 32'd0;
    i_in_valid = 1'b0;
    i_in_sample = 16'd0;
    i_block_ready = 1'b1;
    tick();
    i_start = 1'b1;
    i_load_size = 32'd9;
    i_in_valid = 1'b1;
    tick();
    check_reset_outputs();
    i_rst = 1'b0;
    i_start = 1'b0;
    i_in_valid = 1'b0;
    tick();

    run_file(16, 0, 0, 1'b1, 1'b0);
    run_file(11, 0, 0, 1'b1, 1'b0);
    run_file(20, 0, 3, 1'b0, 1'b0);
    run_file(20, 1, 0, 1'b0, 1'b1);
    run_file(0, 0, 0, 1'b0, 1'b0);
    run_file(800, 1, 0, 1'b0, 1'b0);
    for (int f = 0; f < 6; f++) run_file($urandom_range(1, 40), 2, 2, 1'b0, 1'b0);

    // Abort a file after 5 accepted samples; nothing is expected from it.
    i_load_size = 32'd20;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < 5 && guard < 50) begin
      i_in_valid = 1'b1;
      i_in_sample = 16'($urandom);
      if (o_in_ready) acc++;
      tick();
      guard++;
    end
    chk("pre_reset_accepts", 128'(acc), 128'd5);
    i_in_valid = 1'b0;
    i_rst = 1'b1;
    tick();
    check_reset_outputs();
    i_rst = 1'b0;
    tick();
    run_file(8, 0, 0, 1'b0, 1'b0);
    run_file(0, 0, 0, 1'b0, 1'b0);
    run_file(48000, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
